puf_challenge_ctrl: RTL

- Drives one arbiter-PUF mux21 chain and collects its response.
- Upstream side: generates the per-stage challenge bits (the sel inputs of each mux21 stage) from an LFSR and issues the launch edge into the first stage.
- Downstream side: samples the arbiter output, majority-votes over repeated evaluations per challenge, packs the voted bits into a response word and hands it off with valid/ready.

---
 rtl/puf_challenge_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/puf_challenge_ctrl.sv
// puf_challenge_ctrl
//   Drives one arbiter-PUF mux21 chain and collects its response.
//   An LFSR supplies the per-stage challenge bits. Each challenge is evaluated
//   N_EVAL times by pulsing launch (SETTLE_CYC high, then SETTLE_CYC low), and
//   the sampled arbiter outputs are majority-voted into one response bit.
//   RESP_BITS voted bits are packed MSB-first into resp_out, and the word is
//   handed off with resp_valid/resp_ready.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin one response word (sampled only in IDLE)
//   seed_load, seed_in  load the LFSR seed (IDLE only; a zero seed loads 1)
//   challenge           challenge bits to the mux chain sel inputs
//   launch              race edge into the first stage
//   arb_in              arbiter flip-flop output of the chain
//   resp_out            packed response word
//   resp_valid          resp_out is valid
//   resp_ready          consumer accepts resp_out
//   busy                high in every state except IDLE
//
// Build option
//   PUF_SYNC_EN  adds a 2-flop synchronizer on arb_in and stretches the
//                LAUNCH phase by 2 cycles to cover the synchronizer delay.
module puf_challenge_ctrl #(
  parameter int N_STAGES   = 64,
  parameter int RESP_BITS  = 8,
  parameter int N_EVAL     = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 seed_load,
  input  logic [N_STAGES-1:0]  seed_in,
  output logic [N_STAGES-1:0]  challenge,
  output logic                 launch,
  input  logic                 arb_in,
  output logic [RESP_BITS-1:0] resp_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
);

`ifdef PUF_SYNC_EN
  localparam int LAUNCH_CYC = SETTLE_CYC + 2;
`else
  localparam int LAUNCH_CYC = SETTLE_CYC;
`endif

  localparam int CYC_W  = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;
  localparam int EVAL_W = $clog2(N_EVAL + 1);
  localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LAUNCH,
    RELAX,
    VOTE,
    DONE
  } state_t;

  state_t               state;
  logic [CYC_W-1:0]     cyc_cnt;
  logic [EVAL_W-1:0]    eval_cnt;
  logic [EVAL_W-1:0]    ones_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [RESP_BITS-1:0] resp_sh;
  logic [RESP_BITS-1:0] resp_next;
  logic [N_STAGES-1:0]  lfsr_next;
  logic                 voted;
  logic                 arb_use;

`ifdef PUF_SYNC_EN
  logic [1:0] arb_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_sync <= '0;
    end else begin
      arb_sync <= {arb_sync[0], arb_in};
    end
  end

  assign arb_use = arb_sync[1];
`else
  assign arb_use = arb_in;
`endif

  always_comb begin
    voted     = (ones_cnt > EVAL_W'(N_EVAL / 2));
    // Cast drops the old MSB so RESP_BITS == 1 needs no special case.
    resp_next = RESP_BITS'({resp_sh, voted});
    lfsr_next = {challenge[N_STAGES-2:0],
                 challenge[N_STAGES-1] ^ challenge[N_STAGES-2] ^
                 challenge[N_STAGES-4] ^ challenge[N_STAGES-5]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      challenge  <= N_STAGES'(1);
      launch     <= 1'b0;
      resp_out   <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      cyc_cnt    <= '0;
      eval_cnt   <= '0;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      resp_sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          resp_sh <= '0;
          if (seed_load) begin
            // An all-zero state would lock the LFSR up.
            challenge <= (seed_in == '0) ? N_STAGES'(1) : seed_in;
          end else if (start) begin
            state <= SETUP;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          eval_cnt <= '0;
          ones_cnt <= '0;
          cyc_cnt  <= '0;
          launch   <= 1'b1;
          state    <= LAUNCH;
        end
        LAUNCH: begin
          if (cyc_cnt == CYC_W'(LAUNCH_CYC - 1)) begin
            cyc_cnt <= '0;
            if (arb_use) ones_cnt <= ones_cnt + EVAL_W'(1);
            launch  <= 1'b0;
            state   <= RELAX;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        RELAX: begin
          if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) begin
            cyc_cnt  <= '0;
            eval_cnt <= eval_cnt + EVAL_W'(1);
            if (eval_cnt == EVAL_W'(N_EVAL - 1)) begin
              state <= VOTE;
            end else begin
              launch <= 1'b1;
              state  <= LAUNCH;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        VOTE: begin
          resp_sh   <= resp_next;
          challenge <= lfsr_next;
          if (bit_cnt == BIT_W'(RESP_BITS - 1)) begin
            resp_out   <= resp_next;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            state   <= SETUP;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          launch <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
